// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 encodings, FSM states and the divide special-case selector.
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    typedef enum logic [1:0] {SPEC_ONES, SPEC_DIVIDEND, SPEC_ZERO} spec_t;

    // Divide-by-zero gives all ones (quotient) or the dividend (remainder);
    // signed overflow gives the dividend itself (-2^(XLEN-1)) or zero.
    function automatic spec_t special_kind(input logic is_rem, input logic div_zero);
        if (div_zero)
            return is_rem ? SPEC_DIVIDEND : SPEC_ONES;
        return is_rem ? SPEC_ZERO : SPEC_DIVIDEND;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply on {acc, mplier},
// restoring trial subtract for divide on {rem, quot}.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] hi_next,
    output logic [XLEN-1:0] lo_next
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    assign sum     = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
    assign shifted = {hi, lo[XLEN-1]};
    assign diff    = shifted - {1'b0, b};

    always_comb begin
        if (!is_div) begin
            hi_next = sum[XLEN:1];
            lo_next = {sum[0], lo[XLEN-1:1]};
        end else if (!diff[XLEN]) begin
            // No borrow: the shifted remainder covered the divisor.
            hi_next = diff[XLEN-1:0];
            lo_next = {lo[XLEN-2:0], 1'b1};
        end else begin
            hi_next = shifted[XLEN-1:0];
            lo_next = {lo[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: IDLE -> CALC (XLEN steps) -> DONE,
// valid/ready on both sides, destination tag carried with the op.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  rs2,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] tag_out
);

    localparam int CNT_W = $clog2(XLEN);

    state_t           state, state_d;
    logic [CNT_W-1:0] count;
    logic [2:0]       op_q;
    logic             neg_q, neg_r;
    logic [XLEN-1:0]  hi, lo, b;
    logic [XLEN-1:0]  step_hi, step_lo;
    logic             accept;

    logic             a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]  a_mag, b_mag;
    logic             div_zero, overflow, special;
    logic [XLEN-1:0]  spec_res;
    logic [2*XLEN-1:0] product, prod_fix;
    logic [XLEN-1:0]  result_d;

    assign a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    assign b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    assign a_neg    = a_signed & rs1[XLEN-1];
    assign b_neg    = b_signed & rs2[XLEN-1];
    assign a_mag    = a_neg ? -rs1 : rs1;
    assign b_mag    = b_neg ? -rs2 : rs2;

    assign div_zero = (rs2 == '0);
    assign overflow = ((op == OP_DIV) || (op == OP_REM)) &&
                      (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
    assign special  = op[2] & (div_zero | overflow);

    always_comb begin
        case (special_kind(op[1], div_zero))
            SPEC_ONES:     spec_res = '1;
            SPEC_DIVIDEND: spec_res = rs1;
            default:       spec_res = '0;
        endcase
    end

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div  (op_q[2]),
        .hi      (hi),
        .lo      (lo),
        .b       (b),
        .hi_next (step_hi),
        .lo_next (step_lo)
    );

    // Sign fix on the final iteration's output, so the result lands with the DONE transition.
    assign product  = {step_hi, step_lo};
    assign prod_fix = neg_q ? -product : product;

    always_comb begin
        case (op_q)
            OP_MUL:                       result_d = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              result_d = neg_q ? -step_lo : step_lo;
            default:                      result_d = neg_r ? -step_hi : step_hi;
        endcase
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid && !flush) begin
                    accept  = 1'b1;
                    state_d = special ? DONE : CALC;
                end
            end
            CALC: begin
                if (flush)            state_d = IDLE;
                else if (count == '0) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (flush || out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            count   <= '0;
            op_q    <= OP_MUL;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            b       <= '0;
            result  <= '0;
            tag_out <= '0;
        end else begin
            state <= state_d;
            if (accept) begin
                op_q    <= op;
                neg_q   <= a_neg ^ b_neg;
                neg_r   <= a_neg;
                tag_out <= tag_in;
                count   <= CNT_W'(XLEN - 1);
                hi      <= '0;
                lo      <= op[2] ? a_mag : b_mag;
                b       <= op[2] ? b_mag : a_mag;
                if (special) result <= spec_res;
            end else if (state == CALC && !flush) begin
                hi <= step_hi;
                lo <= step_lo;
                if (count == '0) result <= result_d;
                else             count  <= count - 1'b1;
            end
        end
    end

endmodule
